// File: rtl/pipelined_compressor_tree_acc_if.sv
// pipelined_compressor_tree_acc_if: beat input (valid/first/last + terms) and carry/sum result bundle.
interface pipelined_compressor_tree_acc_if #(
    parameter int NUM_ELEMENTS = 9,
    parameter int BIT_LEN      = 16
);
    logic               in_valid;
    logic               in_first;
    logic               in_last;
    logic [BIT_LEN-1:0] terms [NUM_ELEMENTS];
    logic               out_valid;
    logic [BIT_LEN-1:0] out_C;
    logic [BIT_LEN-1:0] out_S;

    modport master (output in_valid, in_first, in_last, terms, input out_valid, out_C, out_S);
    modport slave  (input in_valid, in_first, in_last, terms, output out_valid, out_C, out_S);
endinterface

// File: rtl/pipelined_compressor_tree_acc.sv
// pipelined_compressor_tree_acc: pipelined 3:2 reduction tree feeding a carry-save accumulator.
module pipelined_compressor_tree_acc #(
    parameter int NUM_ELEMENTS     = 9,
    parameter int BIT_LEN          = 16,
    parameter int LEVELS_PER_STAGE = 2
) (
    input logic clk,
    input logic reset,
    pipelined_compressor_tree_acc_if.slave bus
);
    localparam int N = NUM_ELEMENTS;
    localparam int W = BIT_LEN;

    function automatic int cnt(input int lv);
        int n = N;
        for (int i = 0; i < lv; i++) n = n > 2 ? 2 * (n / 3) + n % 3 : n;
        return n;
    endfunction

    function automatic int nlev();
        int n = N;
        int l = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + n % 3;
            l++;
        end
        return l;
    endfunction

    localparam int L      = nlev();
    localparam int STAGES = L == 0 ? 1 : (L + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

    // Level l computes c from level l-1's v; v is c, or c registered at a stage boundary.
    for (genvar l = 0; l <= L; l++) begin : g_lvl
        localparam int CI = l == 0 ? N : cnt(l - 1);
        localparam int G  = CI / 3;
        localparam bit R  = l == 0 ? L == 0 : (l % LEVELS_PER_STAGE == 0 || l == L);
        logic [W-1:0] c [N];
        logic [W-1:0] v [N];
        for (genvar j = 0; j < N; j++) begin : g_t
            if (l == 0) begin : g_in
                assign c[j] = bus.terms[j];
            end else if (j < 2 * G) begin : g_csa
                localparam int K = 3 * (j / 2);
                if (j % 2 == 0) begin : g_s
                    assign c[j] = g_lvl[l-1].v[K] ^ g_lvl[l-1].v[K+1] ^ g_lvl[l-1].v[K+2];
                end else begin : g_c
                    assign c[j] = ((g_lvl[l-1].v[K] & g_lvl[l-1].v[K+1]) | (g_lvl[l-1].v[K] & g_lvl[l-1].v[K+2])
                                  | (g_lvl[l-1].v[K+1] & g_lvl[l-1].v[K+2])) << 1;
                end
            end else if (j < 2 * G + CI % 3) begin : g_pass
                assign c[j] = g_lvl[l-1].v[G + j];
            end else begin : g_nil
                assign c[j] = '0;
            end
        end
        if (R) begin : g_reg
            always_ff @(posedge clk) begin
                for (int j = 0; j < N; j++) v[j] <= c[j];
            end
        end else begin : g_wire
            assign v = c;
        end
    end

    logic [W-1:0] t_c, t_s;
    assign t_s = g_lvl[L].v[0];
    if (cnt(L) > 1) begin : g_tc
        assign t_c = g_lvl[L].v[1];
    end else begin : g_tz
        assign t_c = '0;
    end

    // {valid, first, last} travels alongside the tree data, one entry per stage.
    logic [2:0] flg_q [STAGES];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) flg_q[i] <= '0;
        end else begin
            flg_q[0] <= {bus.in_valid, bus.in_first, bus.in_last};
            for (int i = 1; i < STAGES; i++) flg_q[i] <= flg_q[i-1];
        end
    end

    logic         vld, fst, lst;
    logic [W-1:0] ac_q, as_q, ac_d, as_d, s1, c1, s2, c2;
    logic         ov_q;
    assign {vld, fst, lst} = flg_q[STAGES-1];

    always_comb begin
        s1   = t_c ^ t_s ^ ac_q;
        c1   = ((t_c & t_s) | (t_c & ac_q) | (t_s & ac_q)) << 1;
        s2   = s1 ^ c1 ^ as_q;
        c2   = ((s1 & c1) | (s1 & as_q) | (c1 & as_q)) << 1;
        ac_d = !vld ? ac_q : fst ? t_c : c2;
        as_d = !vld ? as_q : fst ? t_s : s2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ac_q <= '0;
            as_q <= '0;
            ov_q <= 1'b0;
        end else begin
            ac_q <= ac_d;
            as_q <= as_d;
            ov_q <= vld & lst;
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.out_C     = ac_q;
    assign bus.out_S     = as_q;
endmodule

// File: tb/tb_pipelined_compressor_tree_acc.sv
// tb_pipelined_compressor_tree_acc: scoreboard bench for the default configuration plus a parameter sweep.
module tb_pipelined_compressor_tree_acc;
    logic        clk = 1'b0;
    logic        rst_m = 1'b1;
    logic        rst_s = 1'b1;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          ndone = 0;
    bit          started = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    function automatic int stg(input int n, input int lps);
        int k = n;
        int l = 0;
        while (k > 2) begin
            k = 2 * (k / 3) + k % 3;
            l++;
        end
        return l == 0 ? 1 : (l + lps - 1) / lps;
    endfunction

    // Main DUT: N=9, W=16, LPS=2 -> STAGES=2, latency 3
    pipelined_compressor_tree_acc_if #(.NUM_ELEMENTS(9), .BIT_LEN(16)) m ();
    pipelined_compressor_tree_acc #(.NUM_ELEMENTS(9), .BIT_LEN(16), .LEVELS_PER_STAGE(2)) dut (
        .clk(clk), .reset(rst_m), .bus(m)
    );

    logic [15:0] mq [$];
    int unsigned mc [$];

    always @(negedge clk) begin : main_chk
        logic [15:0] e;
        int unsigned ec;
        if (started && m.out_valid) begin
            if (mq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL main_unexpected: out_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e  = mq.pop_front();
                ec = mc.pop_front();
                chk("main_sum", 64'(16'(m.out_C + m.out_S)), 64'(e));
                chk("main_latency", 64'(cyc), 64'(ec));
            end
        end
    end

    task automatic beat(input logic v, input logic f, input logic l, input logic [15:0] base,
                        input logic [15:0] step, input logic [15:0] exp, input bit push);
        for (int i = 0; i < 9; i++) m.terms[i] = base + 16'(i) * step;
        m.in_valid = v;
        m.in_first = f;
        m.in_last  = l;
        if (push) begin
            mq.push_back(exp);
            mc.push_back(cyc + 3);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
    endtask

    typedef struct {
        logic [15:0] base;
        logic [15:0] step;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [7];

    initial begin : main_test
        tbl = '{
            '{16'd1,     16'd1,     16'd45},
            '{16'hFFFF,  16'd0,     16'hFFF7},
            '{16'd0,     16'd0,     16'd0},
            '{16'h8000,  16'd0,     16'h8000},
            '{16'h1000,  16'h1000,  16'hD000},
            '{16'hFFFF,  16'hFFFF,  16'hFFD3},
            '{16'd7,     16'd3,     16'd171}
        };
        m.in_valid = 1'b0;
        m.in_first = 1'b0;
        m.in_last  = 1'b0;
        for (int i = 0; i < 9; i++) m.terms[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst_m = 1'b0;
        started = 1'b1;
        @(negedge clk);
        chk("reset_valid", 64'(m.out_valid), 64'd0);
        chk("reset_C", 64'(m.out_C), 64'd0);
        chk("reset_S", 64'(m.out_S), 64'd0);
        @(posedge clk);
        #1;
        // single-beat sums, back to back
        for (int i = 0; i < 7; i++) beat(1'b1, 1'b1, 1'b1, tbl[i].base, tbl[i].step, tbl[i].exp, 1'b1);
        idle(5);
        // multi-beat wrap
        beat(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'd0, 16'd0, 1'b0);
        beat(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'd0, 16'd0, 1'b0);
        beat(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'd0, 16'hFFE5, 1'b1);
        idle(5);
        // restart discards the open partial sum
        beat(1'b1, 1'b1, 1'b0, 16'd1, 16'd0, 16'd0, 1'b0);
        beat(1'b1, 1'b0, 1'b0, 16'd1, 16'd0, 16'd0, 1'b0);
        beat(1'b1, 1'b1, 1'b1, 16'd2, 16'd0, 16'd18, 1'b1);
        idle(5);
        // gapped stream, then outputs must hold on idle cycles
        beat(1'b1, 1'b1, 1'b0, 16'd1, 16'd0, 16'd0, 1'b0);
        idle(1);
        beat(1'b1, 1'b0, 1'b0, 16'd1, 16'd0, 16'd0, 1'b0);
        idle(1);
        beat(1'b1, 1'b0, 1'b1, 16'd1, 16'd0, 16'd27, 1'b1);
        idle(4);
        repeat (3) begin
            @(negedge clk);
            chk("hold_sum", 64'(16'(m.out_C + m.out_S)), 64'd27);
            chk("hold_valid", 64'(m.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        // reset one cycle after a first/last beat enters
        beat(1'b1, 1'b1, 1'b1, 16'd5, 16'd0, 16'd0, 1'b0);
        rst_m = 1'b1;
        idle(1);
        rst_m = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_valid", 64'(m.out_valid), 64'd0);
            chk("rst_C", 64'(m.out_C), 64'd0);
            chk("rst_S", 64'(m.out_S), 64'd0);
        end
        @(posedge clk);
        #1;
        // first=0 after reset accumulates onto zero, then a fresh single beat
        beat(1'b1, 1'b0, 1'b1, 16'd1, 16'd0, 16'd9, 1'b1);
        beat(1'b1, 1'b1, 1'b1, 16'd2, 16'd0, 16'd18, 1'b1);
        idle(6);
        chk("main_drain", 64'(mq.size()), 64'd0);
        wait (ndone == 6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : sweep_reset
        repeat (2) @(posedge clk);
        #1 rst_s = 1'b0;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    localparam int SN [6] = '{1, 2, 3, 4, 10, 17};
    localparam int SW [6] = '{8, 64, 8, 64, 8, 64};
    localparam int SL [6] = '{1, 3, 3, 1, 1, 3};

    for (genvar g = 0; g < 6; g++) begin : sw
        localparam int N   = SN[g];
        localparam int W   = SW[g];
        localparam int LPS = SL[g];
        pipelined_compressor_tree_acc_if #(.NUM_ELEMENTS(N), .BIT_LEN(W)) bus ();
        pipelined_compressor_tree_acc #(.NUM_ELEMENTS(N), .BIT_LEN(W), .LEVELS_PER_STAGE(LPS)) dut (
            .clk(clk), .reset(rst_s), .bus(bus)
        );

        logic [W-1:0] q [$];
        int unsigned  qc [$];

        always @(negedge clk) begin : sw_chk
            logic [W-1:0] e;
            int unsigned  ec;
            if (!rst_s && bus.out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sweep%0d_unexpected: out_valid=1 expected 0 (cycle %0d)", g, cyc);
                end else begin
                    e  = q.pop_front();
                    ec = qc.pop_front();
                    chk($sformatf("sweep%0d_sum", g), 64'(W'(bus.out_C + bus.out_S)), 64'(e));
                    chk($sformatf("sweep%0d_latency", g), 64'(cyc), 64'(ec));
                end
            end
        end

        initial begin : sw_stim
            logic [W-1:0] acc;
            logic [W-1:0] s;
            int           st;
            st  = stg(N, LPS);
            acc = '0;
            bus.in_valid = 1'b0;
            bus.in_first = 1'b0;
            bus.in_last  = 1'b0;
            for (int i = 0; i < N; i++) bus.terms[i] = '0;
            @(negedge rst_s);
            for (int t = 0; t < 300; t++) begin
                s = '0;
                for (int i = 0; i < N; i++) begin
                    bus.terms[i] = W'({$urandom, $urandom});
                    s += bus.terms[i];
                end
                bus.in_valid = $urandom_range(3) != 0;
                bus.in_first = $urandom_range(3) == 0;
                bus.in_last  = $urandom_range(2) == 0;
                if (bus.in_valid) begin
                    acc = bus.in_first ? s : acc + s;
                    if (bus.in_last) begin
                        q.push_back(acc);
                        qc.push_back(cyc + st + 1);
                    end
                end
                @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b0;
            repeat (st + 4) @(posedge clk);
            #1 chk($sformatf("sweep%0d_drain", g), 64'(q.size()), 64'd0);
            ndone++;
        end
    end
endmodule

// File: doc/pipelined_compressor_tree_acc.md
# pipelined_compressor_tree_acc

Parametrised, pipelined 3:2 compressor tree with a carry-save accumulator. It reduces NUM_ELEMENTS terms per beat to a redundant carry/sum pair, with a register boundary every LEVELS_PER_STAGE CSA levels. It can also sum a multi-beat stream of term sets into one carry/sum result. It sits in the modular-squaring datapath wherever partial products arrive over several cycles or the reduction depth breaks timing.

## Interface
- NUM_ELEMENTS, 9, terms per beat (>=1)
- BIT_LEN, 16, width of every term and of C/S; all arithmetic is mod 2^BIT_LEN
- LEVELS_PER_STAGE, 2, CSA levels between pipeline registers (>=1)
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  beat carries valid terms
- in_first  input  1  beat starts a new accumulation; qualified by in_valid
- in_last  input  1  beat ends the accumulation; qualified by in_valid
- terms  input  BIT_LEN x NUM_ELEMENTS (unpacked array)  operands
- out_valid  output  1  one-cycle pulse; out_C/out_S hold a completed accumulation
- out_C  output  BIT_LEN  carry vector, already shifted left by 1
- out_S  output  BIT_LEN  sum vector

## Operation
- Level count L: set n=NUM_ELEMENTS; while n>2, apply n = 2*floor(n/3) + n%3 and add 1 to L. Examples: N=9 gives L=4; N=3 gives L=1; N<=2 gives L=0.
- Each level groups terms in threes from index 0 and replaces each group with a CSA (sum, carry<<1, MSB dropped). Leftover terms pass through unchanged, in order.
- STAGES = max(1, ceil(L/LEVELS_PER_STAGE)). A register follows each group of LEVELS_PER_STAGE levels; the last group may be shorter. For L=0 the single stage is a plain register holding terms[0] as S and terms[1] (or 0) as C.
- in_valid, in_first and in_last travel with the data through every stage in a valid/flag shift pipe. The pipe has no backpressure and no stall; a new beat may enter every cycle.
- Accumulate stage (one register, after the tree) uses tree outputs tC, tS and accumulator registers aC, aS.
  - Valid beat with first=1: aC,aS = tC,tS.
  - Valid beat with first=0: aC,aS = 4:2 compress of (tC, tS, aC, aS). This is two chained CSA levels, each carry shifted left 1 with the MSB dropped.
  - No valid beat: aC,aS hold.
- A valid beat with last=1 pulses out_valid in the same cycle its result loads into aC/aS. out_C/out_S are aC/aS directly, so they are stable until the next valid beat.
- first=1 with last=1 in the same beat is a single-beat sum.
- first=1 while an accumulation is open discards the partial sum and starts over. No error is flagged.
- A valid beat with first=0 after reset, before any first, accumulates onto the zeroed accumulator.
- Invariant: out_C + out_S ≡ sum of all terms from the first beat through the last beat (mod 2^BIT_LEN).

## Timing
- Latency: a beat presented at edge k has its accumulate result and any out_valid at edge k+STAGES+1. N=9 and LPS=2 give 3 cycles.
- Throughput: one beat per cycle, sustained indefinitely.
- Critical path: at most LEVELS_PER_STAGE CSA levels, or 2 CSA levels in the accumulate stage.
- Reset: clears every valid/first/last pipe bit, aC, aS, out_valid, out_C and out_S to 0 on the next edge.
  - Beats in flight at reset are lost.
  - in_valid is ignored in the reset cycle itself.
  - Tree data registers need not be cleared.
- out_valid is never asserted in two consecutive cycles unless two consecutive valid beats both carry last=1.

## Test plan
- Single beat: N=9, W=16, LPS=2, terms 1..9, first=last=1 at edge 0. Expect out_valid at edge 3 only, and out_C+out_S mod 2^16 = 45.
- Multi-beat wrap: three back-to-back beats of all 0xFFFF (first on beat 0, last on beat 2). Expect one out_valid, 5 cycles after beat 0, with out_C+out_S mod 2^16 = 0xFFE5.
- Restart: two beats of all 1, then first=1 on a beat of all 2 with last=1. Expect one out_valid with sum 18; the earlier 9+9 is discarded.
- Gapped stream: beats with in_valid toggling 1,0,1,0,1, first on the first beat and last on the third, each of all 1. Expect sum 27, and out_C/out_S stable on idle cycles.
- Reset mid-operation: assert reset one cycle after a first/last beat enters. Expect no out_valid, all outputs 0, and a correct result from a fresh beat issued after reset.
- Parameter sweep: N ∈ {1,2,3,4,10,17}, W ∈ {8,64}, LPS ∈ {1,3}, with random streams against a scoreboard sum mod 2^W. Expect latency = STAGES+1.
